// File: rtl/rv32i_types.sv
// Shared types for the branch predictor table write sequencer: update record,
// sequencer states and table geometry.
package rv32i_types;

  localparam int unsigned BP_IDX_W = 4;
  localparam int unsigned BP_TAG_W = 26;
  localparam int unsigned BP_SETS  = 16;

  typedef struct packed {
    logic [BP_IDX_W-1:0] index;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    logic                taken;
    logic                wr_tag;
    logic                wr_btb;
    logic                wr_bht;
  } bp_upd_t;

  typedef enum logic [1:0] {
    BPS_INIT,
    BPS_IDLE,
    BPS_CLEAR
  } bp_seq_state_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO of branch-resolution updates; head is visible
// combinationally and flush empties it in one cycle.
module bp_upd_fifo
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  logic    pop_i,
  input  logic    flush_i,
  input  bp_upd_t data_i,
  output logic    full_o,
  output logic    empty_o,
  output bp_upd_t head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW:0] wptr_q, wptr_d;
  logic [PtrW:0] rptr_q, rptr_d;
  bp_upd_t       mem_q [DEPTH];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign head_o  = mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_table_sequencer.sv
// Single write port owner for the predictor tag/BTB/BHT arrays: invalidation
// sweeps, buffered EX updates and config writes, with a starvation guard.
module bp_table_sequencer
  import rv32i_types::*;
#(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned TAG_W      = 26,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_req_i,
  input  logic             upd_valid_i,
  output logic             upd_ready_o,
  input  logic [IDX_W-1:0] upd_index_i,
  input  logic [TAG_W-1:0] upd_tag_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_taken_i,
  input  logic             upd_wr_tag_i,
  input  logic             upd_wr_btb_i,
  input  logic             upd_wr_bht_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [IDX_W-1:0] cfg_index_i,
  input  logic [TAG_W-1:0] cfg_tag_i,
  input  logic [31:0]      cfg_target_i,
  input  logic             cfg_taken_i,
  output logic [IDX_W-1:0] tbl_windex_o,
  output logic [TAG_W-1:0] tbl_tag_in_o,
  output logic [31:0]      tbl_btb_in_o,
  output logic             tbl_bht_in_o,
  output logic             load_tag_o,
  output logic             load_btb_o,
  output logic             load_bht_o,
  output logic             pred_disable_o,
  output logic             busy_o
);

  localparam int unsigned      StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BP_SETS - 1);

  bp_seq_state_t      state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [StarveW-1:0] starve_q, starve_d;

  logic    fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  bp_upd_t upd_entry, head;

  assign upd_entry = '{index: upd_index_i, tag: upd_tag_i, target: upd_target_i,
                       taken: upd_taken_i, wr_tag: upd_wr_tag_i, wr_btb: upd_wr_btb_i,
                       wr_bht: upd_wr_bht_i};

  bp_upd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .flush_i(fifo_flush),
    .data_i (upd_entry),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );

  assign busy_o = (state_q != BPS_IDLE) || !fifo_empty;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    starve_d       = starve_q;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;
    upd_ready_o    = 1'b0;
    cfg_ready_o    = 1'b0;
    pred_disable_o = 1'b1;
    load_tag_o     = 1'b0;
    load_btb_o     = 1'b0;
    load_bht_o     = 1'b0;
    tbl_windex_o   = '0;
    tbl_tag_in_o   = '0;
    tbl_btb_in_o   = '0;
    tbl_bht_in_o   = 1'b0;
    unique case (state_q)
      BPS_INIT, BPS_CLEAR: begin
        // Gated by rst_n so the enables drop the instant reset asserts.
        load_tag_o   = rst_n;
        load_btb_o   = rst_n;
        load_bht_o   = rst_n;
        tbl_windex_o = cnt_q;
        if (flush_req_i) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIdx) state_d = BPS_IDLE;
        end
      end
      BPS_IDLE: begin
        pred_disable_o = 1'b0;
        upd_ready_o    = !fifo_full && !flush_req_i;
        fifo_push      = upd_valid_i && upd_ready_o;
        if (flush_req_i) begin
          state_d    = BPS_CLEAR;
          cnt_d      = '0;
          starve_d   = '0;
          fifo_flush = 1'b1;
        end else if (!fifo_empty &&
                     !(cfg_valid_i && starve_q == StarveW'(STARVE_MAX))) begin
          load_tag_o   = head.wr_tag;
          load_btb_o   = head.wr_btb;
          load_bht_o   = head.wr_bht;
          tbl_windex_o = head.index;
          tbl_tag_in_o = head.tag;
          tbl_btb_in_o = head.target;
          tbl_bht_in_o = head.taken;
          fifo_pop     = 1'b1;
          starve_d     = cfg_valid_i ? starve_q + 1'b1 : '0;
        end else if (cfg_valid_i) begin
          load_tag_o   = 1'b1;
          load_btb_o   = 1'b1;
          load_bht_o   = 1'b1;
          tbl_windex_o = cfg_index_i;
          tbl_tag_in_o = cfg_tag_i;
          tbl_btb_in_o = cfg_target_i;
          tbl_bht_in_o = cfg_taken_i;
          cfg_ready_o  = 1'b1;
          starve_d     = '0;
        end
      end
      default: state_d = BPS_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BPS_INIT;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_bp_table_sequencer.sv
// Bench for bp_table_sequencer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bp_table_sequencer;
  import rv32i_types::*;

  localparam int unsigned IDX_W      = 4;
  localparam int unsigned TAG_W      = 26;
  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush_req, upd_valid, upd_ready;
  logic [IDX_W-1:0] upd_index;
  logic [TAG_W-1:0] upd_tag;
  logic [31:0]      upd_target;
  logic             upd_taken, upd_wr_tag, upd_wr_btb, upd_wr_bht;
  logic             cfg_valid, cfg_ready;
  logic [IDX_W-1:0] cfg_index;
  logic [TAG_W-1:0] cfg_tag;
  logic [31:0]      cfg_target;
  logic             cfg_taken;
  logic [IDX_W-1:0] tbl_windex;
  logic [TAG_W-1:0] tbl_tag_in;
  logic [31:0]      tbl_btb_in;
  logic             tbl_bht_in, load_tag, load_btb, load_bht, pred_disable, busy;

  always #5 clk = ~clk;

  bp_table_sequencer #(
    .IDX_W(IDX_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_req_i(flush_req),
    .upd_valid_i(upd_valid), .upd_ready_o(upd_ready), .upd_index_i(upd_index),
    .upd_tag_i(upd_tag), .upd_target_i(upd_target), .upd_taken_i(upd_taken),
    .upd_wr_tag_i(upd_wr_tag), .upd_wr_btb_i(upd_wr_btb), .upd_wr_bht_i(upd_wr_bht),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_index_i(cfg_index),
    .cfg_tag_i(cfg_tag), .cfg_target_i(cfg_target), .cfg_taken_i(cfg_taken),
    .tbl_windex_o(tbl_windex), .tbl_tag_in_o(tbl_tag_in), .tbl_btb_in_o(tbl_btb_in),
    .tbl_bht_in_o(tbl_bht_in), .load_tag_o(load_tag), .load_btb_o(load_btb),
    .load_bht_o(load_bht), .pred_disable_o(pred_disable), .busy_o(busy)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep position (-1 when not sweeping), pending update queue,
  // and the number of back-to-back update grants while a config write waits.
  bp_upd_t mq[$];
  int      sweep_idx = 0;
  int      starve = 0;

  always @(negedge rst_n) begin
    sweep_idx = 0;
    mq.delete();
    starve = 0;
  end

  task automatic model_step();
    logic    e_lt, e_lb, e_lh, e_ur, e_cr, e_pd, e_busy;
    bp_upd_t w, in_e;
    e_lt = 1'b0; e_lb = 1'b0; e_lh = 1'b0; e_cr = 1'b0; w = '0;
    in_e = '{index: upd_index, tag: upd_tag, target: upd_target, taken: upd_taken,
             wr_tag: upd_wr_tag, wr_btb: upd_wr_btb, wr_bht: upd_wr_bht};
    if (sweep_idx >= 0) begin
      e_lt = 1'b1; e_lb = 1'b1; e_lh = 1'b1;
      w.index = IDX_W'(sweep_idx);
      e_ur = 1'b0; e_pd = 1'b1; e_busy = 1'b1;
      if (flush_req) sweep_idx = 0;
      else if (sweep_idx == int'(BP_SETS) - 1) sweep_idx = -1;
      else sweep_idx++;
    end else begin
      e_pd   = 1'b0;
      e_busy = (mq.size() != 0);
      e_ur   = (mq.size() < int'(DEPTH)) && !flush_req;
      if (flush_req) begin
        mq.delete();
        starve = 0;
        sweep_idx = 0;
      end else if (mq.size() != 0 && !(cfg_valid && starve == int'(STARVE_MAX))) begin
        w = mq.pop_front();
        e_lt = w.wr_tag; e_lb = w.wr_btb; e_lh = w.wr_bht;
        starve = cfg_valid ? starve + 1 : 0;
      end else if (cfg_valid) begin
        w.index = cfg_index; w.tag = cfg_tag; w.target = cfg_target; w.taken = cfg_taken;
        e_lt = 1'b1; e_lb = 1'b1; e_lh = 1'b1; e_cr = 1'b1;
        starve = 0;
      end
      if (upd_valid && e_ur) mq.push_back(in_e);
    end
    chk("m_load_tag", 32'(load_tag), 32'(e_lt));
    chk("m_load_btb", 32'(load_btb), 32'(e_lb));
    chk("m_load_bht", 32'(load_bht), 32'(e_lh));
    chk("m_upd_ready", 32'(upd_ready), 32'(e_ur));
    chk("m_cfg_ready", 32'(cfg_ready), 32'(e_cr));
    chk("m_pred_disable", 32'(pred_disable), 32'(e_pd));
    chk("m_busy", 32'(busy), 32'(e_busy));
    if (e_lt || e_lb || e_lh) chk("m_windex", 32'(tbl_windex), 32'(w.index));
    if (e_lt) chk("m_tag_in", 32'(tbl_tag_in), 32'(w.tag));
    if (e_lb) chk("m_btb_in", tbl_btb_in, w.target);
    if (e_lh) chk("m_bht_in", 32'(tbl_bht_in), 32'(w.taken));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_loads", 32'({load_tag, load_btb, load_bht}), 32'(0));
      chk("rst_readies", 32'({upd_ready, cfg_ready}), 32'(0));
      chk("rst_pd_busy", 32'({pred_disable, busy}), 32'(3));
    end else begin
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && g < 100) begin
      tick();
      g++;
    end
    chk(name, 32'(busy), 32'(0));
  endtask

  task automatic check_sweep(input string name);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk(name, 32'(tbl_windex), 32'(k));
      chk({name, "_pd"}, 32'({pred_disable, load_tag}), 32'(3));
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    logic au, ac;
    flush_req = 0; upd_valid = 0; upd_index = '0; upd_tag = '0; upd_target = '0;
    upd_taken = 0; upd_wr_tag = 0; upd_wr_btb = 0; upd_wr_bht = 0;
    cfg_valid = 0; cfg_index = '0; cfg_tag = '0; cfg_target = '0; cfg_taken = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: init sweep then idle
    check_sweep("t1_windex");
    @(negedge clk);
    chk("t1_idle", 32'({pred_disable, busy}), 32'(0));

    // 2: single update writing only BTB and BHT
    tick();
    upd_valid = 1; upd_index = 4'd5; upd_tag = 26'h123; upd_target = 32'h100;
    upd_taken = 1; upd_wr_tag = 0; upd_wr_btb = 1; upd_wr_bht = 1;
    @(negedge clk);
    chk("t2_accept", 32'(upd_ready), 32'(1));
    chk("t2_no_bypass", 32'({load_tag, load_btb, load_bht}), 32'(0));
    tick();
    upd_valid = 0;
    @(negedge clk);
    chk("t2_loads", 32'({load_tag, load_btb, load_bht}), 32'(3));
    chk("t2_windex", 32'(tbl_windex), 32'(5));
    chk("t2_btb", tbl_btb_in, 32'h100);
    chk("t2_bht", 32'(tbl_bht_in), 32'(1));
    tick();
    @(negedge clk);
    chk("t2_busy", 32'(busy), 32'(0));

    // 3: fill FIFO while cfg pending, then flush drops the queued updates
    tick();
    cfg_valid = 1; cfg_index = 4'hA; cfg_tag = 26'h3A; cfg_target = 32'hCAFE0000;
    cfg_taken = 0;
    upd_valid = 1; upd_wr_tag = 1; upd_wr_btb = 1; upd_wr_bht = 1;
    g = 0;
    while (upd_ready && g < 40) begin
      upd_index = IDX_W'(g); upd_target = 32'($urandom);
      tick();
      g++;
    end
    chk("t3_full", 32'(upd_ready), 32'(0));
    flush_req = 1; upd_valid = 0;
    @(negedge clk);
    chk("t3_flush_block", 32'({load_tag, load_btb, load_bht, cfg_ready}), 32'(0));
    tick();
    flush_req = 0;
    check_sweep("t3_sweep");
    @(negedge clk);
    chk("t3_cfg_grant", 32'({cfg_ready, load_tag}), 32'(3));
    chk("t3_cfg_index", 32'(tbl_windex), 32'hA);
    tick();
    cfg_valid = 0;
    @(negedge clk);
    chk("t3_empty", 32'({busy, load_tag, load_btb, load_bht}), 32'(0));

    // 4: starvation guard: 4 update writes, 1 cfg write, updates resume
    tick();
    upd_valid = 1; upd_index = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      upd_index = IDX_W'(k);
      cfg_valid = (k <= 5); cfg_index = 4'hE;
      @(negedge clk);
      if (k == 5) begin
        chk("t4_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("t4_cfg_index", 32'(tbl_windex), 32'hE);
      end else begin
        chk("t4_cfg_ready", 32'(cfg_ready), 32'(0));
        chk("t4_upd_index", 32'(tbl_windex), 32'(k < 5 ? k - 1 : 4));
      end
    end
    tick();
    upd_valid = 0; cfg_valid = 0;
    wait_idle("t4_drain");

    // 5: flush and update in the same idle cycle
    tick();
    upd_valid = 1; upd_index = 4'd7; flush_req = 1;
    @(negedge clk);
    chk("t5_ready", 32'(upd_ready), 32'(0));
    tick();
    upd_valid = 0; flush_req = 0;
    @(negedge clk);
    chk("t5_sweep0", 32'(tbl_windex), 32'(0));

    // 6: async reset mid-sweep at index 9, then flush restart at index 12
    g = 0;
    tick();
    while (tbl_windex != 4'd9 && g < 40) begin
      tick();
      g++;
    end
    chk("t6_reach9", 32'(tbl_windex), 32'(9));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_loads", 32'({load_tag, load_btb, load_bht}), 32'(0));
    chk("t6_rst_pd_busy", 32'({pred_disable, busy, upd_ready}), 32'(6));
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      if (k == 12) flush_req = 1;
      @(negedge clk);
      chk("t6_init", 32'(tbl_windex), 32'(k));
      tick();
      flush_req = 0;
    end
    check_sweep("t6_restart");
    @(negedge clk);
    chk("t6_idle", 32'({pred_disable, busy}), 32'(0));

    // Randomized traffic; requesters hold until accepted
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      au = upd_valid && upd_ready;
      ac = cfg_valid && cfg_ready;
      tick();
      if (!upd_valid || au) begin
        upd_valid  = ($urandom % 3) != 0;
        upd_index  = IDX_W'($urandom);
        upd_tag    = TAG_W'($urandom);
        upd_target = $urandom;
        upd_taken  = 1'($urandom);
        upd_wr_tag = 1'($urandom);
        upd_wr_btb = 1'($urandom);
        upd_wr_bht = 1'($urandom);
      end
      if (!cfg_valid || ac) begin
        cfg_valid  = ($urandom % 4) == 0;
        cfg_index  = IDX_W'($urandom);
        cfg_tag    = TAG_W'($urandom);
        cfg_target = $urandom;
        cfg_taken  = 1'($urandom);
      end
      flush_req = ($urandom % 50) == 0;
    end
    tick();
    upd_valid = 0; cfg_valid = 0; flush_req = 0;
    wait_idle("final_idle");
    summary();
    $finish;
  end

endmodule
